npu_axil_biu: RTL and testbench



---
 rtl/npu_axil_biu.sv | 161 ++++++++++++++++
 tb/tb_npu_axil_biu.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_axil_biu.sv
// AXI4-Lite slave to NPU register-block bridge: one register access per host
// transaction, read/write alternation on contention, and an ack timeout.
module npu_axil_biu #(
    parameter int AW     = 20,
    parameter int DW     = 64,
    parameter int TO_CYC = 255
) (
    input  logic            clk_trans,
    input  logic            rst_n,
    input  logic [AW-1:0]   s_awaddr,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [DW-1:0]   s_wdata,
    input  logic [DW/8-1:0] s_wstrb,
    input  logic            s_wvalid,
    output logic            s_wready,
    output logic [1:0]      s_bresp,
    output logic            s_bvalid,
    input  logic            s_bready,
    input  logic [AW-1:0]   s_araddr,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [DW-1:0]   s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [AW-1:0]   reg_addr,
    output logic [DW-1:0]   reg_wdata,
    output logic [7:0]      reg_sel,
    output logic            reg_wen,
    output logic            reg_ren,
    input  logic [DW-1:0]   reg_rdata,
    input  logic            reg_err,
    input  logic            reg_ack
);

    typedef enum logic [2:0] {IDLE, WACC, RACC, BRSP, RRSP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [7:0]      sel_q;
    logic            wen_q;
    logic            ren_q;
    logic [7:0]      cnt_q;
    logic            last_wr_q;
    logic            bvalid_q;
    logic [1:0]      bresp_q;
    logic            rvalid_q;
    logic [1:0]      rresp_q;
    logic [DW-1:0]   rdata_q;

    logic            wr_req;
    logic            rd_req;
    logic            grant_wr;
    logic            grant_rd;
    logic            acc_done;
    logic [1:0]      acc_resp;
    logic            unused_addr_lsbs;

    assign wr_req   = s_awvalid && s_wvalid;
    assign rd_req   = s_arvalid;
    // On contention the write wins only if the previous grant was a read.
    assign grant_wr = (state_q == IDLE) && wr_req && (!rd_req || !last_wr_q);
    assign grant_rd = (state_q == IDLE) && rd_req && !grant_wr;

    // A same-cycle ack takes priority over the timeout.
    assign acc_done = reg_ack || (cnt_q == TO_LAST);
    assign acc_resp = (reg_ack && !reg_err) ? 2'b00 : 2'b10;

    assign unused_addr_lsbs = ^{s_awaddr[2:0], s_araddr[2:0]};

    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;
    assign s_bresp   = bresp_q;
    assign s_bvalid  = bvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_rvalid  = rvalid_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_sel   = sel_q;
    assign reg_wen   = wen_q;
    assign reg_ren   = ren_q;

    always_ff @(posedge clk_trans or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            cnt_q     <= '0;
            last_wr_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_wr) begin
                        addr_q    <= {s_awaddr[AW-1:3], 3'b000};
                        wdata_q   <= s_wdata;
                        sel_q     <= s_wstrb;
                        wen_q     <= 1'b1;
                        cnt_q     <= '0;
                        last_wr_q <= 1'b1;
                        state_q   <= WACC;
                    end else if (grant_rd) begin
                        addr_q    <= {s_araddr[AW-1:3], 3'b000};
                        ren_q     <= 1'b1;
                        cnt_q     <= '0;
                        last_wr_q <= 1'b0;
                        state_q   <= RACC;
                    end
                end
                WACC: begin
                    if (acc_done) begin
                        wen_q    <= 1'b0;
                        bresp_q  <= acc_resp;
                        bvalid_q <= 1'b1;
                        state_q  <= BRSP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RACC: begin
                    if (acc_done) begin
                        ren_q    <= 1'b0;
                        rresp_q  <= acc_resp;
                        rdata_q  <= reg_ack ? reg_rdata : '0;
                        rvalid_q <= 1'b1;
                        state_q  <= RRSP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                BRSP: begin
                    if (s_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RRSP: begin
                    if (s_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_axil_biu.sv
// Scoreboard bench for npu_axil_biu: expected responses are queued at grant
// time and compared when the B/R channel presents them.
module tb_npu_axil_biu;

    localparam int AW = 20;
    localparam int DW = 64;
    localparam int TO = 8;

    logic            clock = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   s_awaddr;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [AW-1:0]   s_araddr;
    logic            s_arvalid;
    logic            s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_wdata;
    logic [7:0]      reg_sel;
    logic            reg_wen;
    logic            reg_ren;
    logic [DW-1:0]   reg_rdata;
    logic            reg_err;
    logic            reg_ack;

    npu_axil_biu #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
        .clk_trans(clock),  .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata),  .s_wstrb(s_wstrb),  .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp),  .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata),  .s_rresp(s_rresp),  .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_sel(reg_sel),
        .reg_wen(reg_wen),  .reg_ren(reg_ren),  .reg_rdata(reg_rdata),
        .reg_err(reg_err),  .reg_ack(reg_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          isWr;
        logic [1:0]  resp;
        logic [63:0] data;
    } exp_t;

    exp_t sbQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Register-block model: ackMode 0 = same-cycle ack, 1 = never, 2 = ack in access cycle ackAt
    int          ackMode = 0;
    int          ackAt   = 1;
    logic        errVal  = 1'b0;
    logic [63:0] rdVal   = '0;
    int          accCyc  = 0;
    int          cyc     = 0;

    assign reg_ack   = (reg_wen || reg_ren) &&
                       (ackMode == 0 || (ackMode == 2 && accCyc == ackAt - 1));
    assign reg_err   = errVal;
    assign reg_rdata = rdVal;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if ((reg_wen || reg_ren) && !reg_ack) accCyc <= accCyc + 1;
        else                                  accCyc <= 0;
    end

    // Measure how many cycles each reg_wen / reg_ren pulse lasts.
    int wenRun = 0, renRun = 0, lastWenLen = 0, lastRenLen = 0;
    always @(negedge clock) begin
        if (reg_wen) wenRun++;
        else if (wenRun != 0) begin lastWenLen = wenRun; wenRun = 0; end
        if (reg_ren) renRun++;
        else if (renRun != 0) begin lastRenLen = renRun; renRun = 0; end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit doWr, input bit doRd, input logic [AW-1:0] waddr,
                                 input logic [63:0] wd, input logic [7:0] ws,
                                 input logic [AW-1:0] raddr);
        @(negedge clock);
        s_awvalid = doWr;
        s_wvalid  = doWr;
        s_awaddr  = waddr;
        s_wdata   = wd;
        s_wstrb   = ws;
        s_arvalid = doRd;
        s_araddr  = raddr;
    endtask

    // Wait for a grant, check it is the expected kind (1=write, 2=read), queue its response.
    task automatic waitGrant(input string tag, input int expKind, output int hsCyc);
        int   kind;
        bit   timedOut;
        exp_t e;
        kind = 0;
        for (int i = 0; i < 50; i++) begin
            if (i != 0) @(negedge clock);
            #1;
            if (s_awready && s_wready) kind = 1;
            else if (s_arready)        kind = 2;
            if (kind != 0) break;
        end
        hsCyc = cyc;
        checkOutput({tag, "_grant"}, 64'(kind), 64'(expKind));
        if (kind != 0) begin
            timedOut = (ackMode == 1) || (ackMode == 2 && ackAt > TO);
            e.isWr = (expKind == 1);
            e.resp = (timedOut || errVal) ? 2'b10 : 2'b00;
            e.data = (expKind == 1 || timedOut) ? 64'h0 : rdVal;
            sbQ.push_back(e);
            @(posedge clock);
        end
        #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
    endtask

    // Wait for B or R valid, optionally stall ready, pop the scoreboard and compare.
    task automatic waitResp(input string tag, input int holdLow, output int respCyc);
        bit          seen;
        bit          stable;
        exp_t        e;
        logic [63:0] snapD;
        logic [1:0]  snapR;
        seen = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 300; i++) begin
            if (s_bvalid || s_rvalid) begin seen = 1'b1; break; end
            @(negedge clock);
        end
        respCyc = cyc;
        if (!seen) begin
            checkOutput({tag, "_resp_seen"}, 64'd0, 64'd1);
            return;
        end
        if (sbQ.size() == 0) begin
            checkOutput({tag, "_sb_nonempty"}, 64'd0, 64'd1);
            return;
        end
        e = sbQ.pop_front();
        checkOutput({tag, "_resp_chan"}, 64'(s_bvalid), 64'(e.isWr));
        if (e.isWr) begin
            checkOutput({tag, "_bresp"}, 64'(s_bresp), 64'(e.resp));
        end else begin
            checkOutput({tag, "_rresp"}, 64'(s_rresp), 64'(e.resp));
            checkOutput({tag, "_rdata"}, s_rdata, e.data);
        end
        if (holdLow > 0) begin
            stable = 1'b1;
            snapD  = s_rdata;
            snapR  = s_rresp;
            repeat (holdLow) begin
                @(negedge clock);
                if (!s_rvalid || s_rdata !== snapD || s_rresp !== snapR) stable = 1'b0;
            end
            checkOutput({tag, "_hold_stable"}, 64'(stable), 64'd1);
        end
        if (e.isWr) s_bready = 1'b1;
        else        s_rready = 1'b1;
        @(posedge clock);
        #1;
        s_bready = 1'b0;
        s_rready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 64'(s_bvalid || s_rvalid), 64'd0);
    endtask

    function automatic bit anyOutputHigh();
        return |{s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp,
                 s_rvalid, reg_addr, reg_wdata, reg_sel, reg_wen, reg_ren};
    endfunction

    initial begin
        int hs, rc;
        bit sawAw;
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

        repeat (3) @(negedge clock);
        checkOutput("reset_outputs", 64'(anyOutputHigh()), 64'd0);
        rst_n = 1'b1;

        // Single write, same-cycle ack
        applyStimulus(1, 0, 20'h00000, 64'h1, 8'hFF, 20'h0);
        waitGrant("wr0", 1, hs);
        checkOutput("wr0_wen", 64'(reg_wen), 64'd1);
        checkOutput("wr0_addr", 64'(reg_addr), 64'h0);
        checkOutput("wr0_sel", 64'(reg_sel), 64'hFF);
        checkOutput("wr0_wdata", reg_wdata, 64'h1);
        waitResp("wr0", 0, rc);
        checkOutput("wr0_latency", 64'(rc - hs), 64'd2);
        checkOutput("wr0_wen_len", 64'(lastWenLen), 64'd1);

        // Unaligned read with a stalled R channel
        rdVal = 64'h1122_3344_5566_7788;
        applyStimulus(0, 1, 20'h0, 64'h0, 8'h0, 20'h00403);
        waitGrant("rd0", 2, hs);
        checkOutput("rd0_ren", 64'(reg_ren), 64'd1);
        checkOutput("rd0_addr", 64'(reg_addr), 64'h400);
        waitResp("rd0", 5, rc);
        checkOutput("rd0_latency", 64'(rc - hs), 64'd2);
        checkOutput("rd0_ren_len", 64'(lastRenLen), 64'd1);

        // Error on a write, then a clean read
        errVal = 1'b1;
        applyStimulus(1, 0, 20'h00408, 64'hDEAD_BEEF_0000_0042, 8'h0F, 20'h0);
        waitGrant("wrerr", 1, hs);
        checkOutput("wrerr_addr", 64'(reg_addr), 64'h408);
        checkOutput("wrerr_sel", 64'(reg_sel), 64'h0F);
        waitResp("wrerr", 0, rc);
        errVal = 1'b0;
        rdVal  = 64'h0A0B_0C0D_0E0F_1011;
        applyStimulus(0, 1, 20'h0, 64'h0, 8'h0, 20'h00010);
        waitGrant("rdok", 2, hs);
        waitResp("rdok", 0, rc);

        // Timeout with no ack, then an ack landing on the last allowed cycle
        ackMode = 1;
        applyStimulus(0, 1, 20'h0, 64'h0, 8'h0, 20'h00020);
        waitGrant("rdto", 2, hs);
        waitResp("rdto", 0, rc);
        checkOutput("rdto_latency", 64'(rc - hs), 64'(TO + 1));
        checkOutput("rdto_ren_len", 64'(lastRenLen), 64'(TO));
        ackMode = 2; ackAt = TO; rdVal = 64'hCAFE_F00D_1234_5678;
        applyStimulus(0, 1, 20'h0, 64'h0, 8'h0, 20'h00028);
        waitGrant("rdedge", 2, hs);
        waitResp("rdedge", 0, rc);
        checkOutput("rdedge_ren_len", 64'(lastRenLen), 64'(TO));
        ackMode = 0;

        // Reset in the middle of a write access
        ackMode = 1;
        applyStimulus(1, 0, 20'h00030, 64'h5555, 8'hFF, 20'h0);
        waitGrant("wrrst", 1, hs);
        @(negedge clock);
        checkOutput("wrrst_wen_before", 64'(reg_wen), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("wrrst_outputs", 64'(anyOutputHigh()), 64'd0);
        sbQ.delete();
        ackMode = 0;
        @(negedge clock);
        rst_n = 1'b1;
        applyStimulus(1, 0, 20'h00038, 64'h7777_8888, 8'h3C, 20'h0);
        waitGrant("wrpost", 1, hs);
        checkOutput("wrpost_addr", 64'(reg_addr), 64'h38);
        checkOutput("wrpost_wdata", reg_wdata, 64'h7777_8888);
        waitResp("wrpost", 0, rc);

        // Fresh reset, then contended requests must alternate W,R,W,R
        @(negedge clock); rst_n = 1'b0;
        @(negedge clock); rst_n = 1'b1;
        rdVal = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 20'(32'h100 + i * 8), 64'(i), 8'hFF, 20'(32'h200 + i * 8));
            waitGrant($sformatf("arb%0d", i), (i % 2 == 0) ? 1 : 2, hs);
            waitResp($sformatf("arb%0d", i), 0, rc);
        end

        // Lone awvalid never gets accepted; the read goes through
        @(negedge clock);
        s_awvalid = 1'b1; s_awaddr = 20'h00300; s_arvalid = 1'b1; s_araddr = 20'h00308;
        waitGrant("awalone_rd", 2, hs);
        s_awvalid = 1'b1;
        waitResp("awalone_rd", 0, rc);
        sawAw = 1'b0;
        repeat (10) begin
            @(negedge clock);
            #1;
            if (s_awready || s_wready) sawAw = 1'b1;
        end
        checkOutput("awalone_no_ready", 64'(sawAw), 64'd0);
        s_awvalid = 1'b0;

        checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
